// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use stall detection, and bubble/flush insertion ahead of the ALU.
module id_ex_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR      = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [REG_ADDR-1:0]      id_rs1_addr,
    input  logic [REG_ADDR-1:0]      id_rs2_addr,
    input  logic [REG_ADDR-1:0]      id_rd_addr,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic                     id_alu_src,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     flush,
    input  logic                     exmem_reg_write,
    input  logic [REG_ADDR-1:0]      exmem_rd,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic                     memwb_reg_write,
    input  logic [REG_ADDR-1:0]      memwb_rd,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic                     stall_o,
    output logic                     ex_valid,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [REG_ADDR-1:0]      ex_rd,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic [DATA_WIDTH-1:0]    ex_store_data
);

    typedef struct packed {
        logic                     valid;
        logic [REG_ADDR-1:0]      rs1_addr;
        logic [REG_ADDR-1:0]      rs2_addr;
        logic [REG_ADDR-1:0]      rd_addr;
        logic [DATA_WIDTH-1:0]    rs1_data;
        logic [DATA_WIDTH-1:0]    rs2_data;
        logic [DATA_WIDTH-1:0]    imm;
        logic                     alu_src;
        logic [OPCODE_LENGTH-1:0] alu_op;
        logic                     reg_write;
        logic                     mem_read;
        logic                     mem_write;
    } ex_state_t;

    ex_state_t ex_q;
    ex_state_t ex_d;

    logic                  hazard;
    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;

    // rs2 is compared even for immediate-form instructions; the stall is conservative.
    always_comb begin
        hazard = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != '0) &
                 ((ex_q.rd_addr == id_rs1_addr) | (ex_q.rd_addr == id_rs2_addr));
        stall_o = hazard & ~flush;
    end

    always_comb begin
        ex_d = '0;
        if (!flush && !stall_o) begin
            ex_d.valid     = id_valid;
            ex_d.rs1_addr  = id_rs1_addr;
            ex_d.rs2_addr  = id_rs2_addr;
            ex_d.rd_addr   = id_rd_addr;
            ex_d.rs1_data  = id_rs1_data;
            ex_d.rs2_data  = id_rs2_data;
            ex_d.imm       = id_imm;
            ex_d.alu_src   = id_alu_src;
            ex_d.alu_op    = id_alu_op;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.mem_write = id_mem_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // EX/MEM holds the younger result, so it takes precedence; x0 never forwards.
    always_comb begin
        fwd_rs1 = ex_q.rs1_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_q.rs1_addr)) begin
            fwd_rs1 = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_q.rs1_addr)) begin
            fwd_rs1 = memwb_result;
        end

        fwd_rs2 = ex_q.rs2_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_q.rs2_addr)) begin
            fwd_rs2 = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_q.rs2_addr)) begin
            fwd_rs2 = memwb_result;
        end
    end

    always_comb begin
        SrcA          = fwd_rs1;
        SrcB          = ex_q.alu_src ? ex_q.imm : fwd_rs2;
        ex_store_data = fwd_rs2;
        Operation     = ex_q.alu_op;
        ex_valid      = ex_q.valid;
        ex_rd         = ex_q.valid ? ex_q.rd_addr : '0;
        ex_reg_write  = ex_q.valid & ex_q.reg_write;
        ex_mem_read   = ex_q.valid & ex_q.mem_read;
        ex_mem_write  = ex_q.valid & ex_q.mem_write;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios followed by randomized traffic, all compared against an
// instruction-level reference model of the ID/EX boundary.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        stall_o, ex_valid;
  logic [31:0] SrcA, SrcB, ex_store_data;
  logic [3:0]  Operation;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall_o(stall_o), .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB),
    .Operation(Operation), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data)
  );

  // Reference model: the instruction currently sitting in EX.
  typedef struct {
    bit          valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    bit          src;
    logic [3:0]  op;
    bit          rw, mr, mw;
  } instr_t;

  instr_t m;
  bit     exp_stall;

  function automatic instr_t bubble();
    instr_t b;
    b.valid = 0; b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.d1 = 0; b.d2 = 0; b.imm = 0;
    b.src = 0; b.op = 0; b.rw = 0; b.mr = 0; b.mw = 0;
    return b;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] d);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == a) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == a) return memwb_result;
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    exp_stall = rst_n && id_valid && m.valid && m.mr && m.rd != 0 &&
                (m.rd == id_rs1_addr || m.rd == id_rs2_addr) && !flush;
    check("stall_o", 32'(stall_o), 32'(exp_stall));
    check("ex_valid", 32'(ex_valid), 32'(m.valid));
    check("SrcA", SrcA, operand(m.rs1, m.d1));
    check("SrcB", SrcB, m.src ? m.imm : operand(m.rs2, m.d2));
    check("store_data", ex_store_data, operand(m.rs2, m.d2));
    check("Operation", 32'(Operation), 32'(m.op));
    check("ex_rd", 32'(ex_rd), m.valid ? 32'(m.rd) : 32'd0);
    check("ex_reg_write", 32'(ex_reg_write), 32'(m.valid && m.rw));
    check("ex_mem_read", 32'(ex_mem_read), 32'(m.valid && m.mr));
    check("ex_mem_write", 32'(ex_mem_write), 32'(m.valid && m.mw));
  endtask

  // Check the current cycle, then advance one edge and let the model follow.
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    if (!rst_n || flush || exp_stall) begin
      m = bubble();
    end else begin
      m.valid = id_valid; m.rs1 = id_rs1_addr; m.rs2 = id_rs2_addr; m.rd = id_rd_addr;
      m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm; m.src = id_alu_src;
      m.op = id_alu_op; m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
    end
    @(negedge clk);
  endtask

  task automatic drive_id(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input bit src, input logic [3:0] op,
                          input bit rw, input bit mr, input bit mw);
    id_valid = v; id_rs1_addr = r1; id_rs2_addr = r2; id_rd_addr = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = src;
    id_alu_op = op; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic set_fwd(input bit xw, input logic [4:0] xrd, input logic [31:0] xres,
                         input bit ww, input logic [4:0] wrd, input logic [31:0] wres);
    exmem_reg_write = xw; exmem_rd = xrd; exmem_result = xres;
    memwb_reg_write = ww; memwb_rd = wrd; memwb_result = wres;
  endtask

  initial begin
    m = bubble();
    rst_n = 1'b0;
    flush = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 check_outputs();
    @(negedge clk);

    // Reset asserted mid-cycle while EX and ID hold real work.
    rst_n = 1'b1;
    drive_id(1, 1, 2, 3, 32'h55, 32'h66, 0, 0, 4'h6, 1, 0, 0);
    tick();
    drive_id(1, 1, 2, 3, 32'd5, 32'd7, 0, 0, 4'b0010, 1, 0, 0);
    #2 rst_n = 1'b0;
    m = bubble();
    #1;
    check("rst_ex_valid", 32'(ex_valid), 0);
    check("rst_SrcA", SrcA, 0);
    check("rst_SrcB", SrcB, 0);
    check("rst_Operation", 32'(Operation), 0);
    check("rst_stall", 32'(stall_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1;
    check("add_SrcA", SrcA, 32'd5);
    check("add_SrcB", SrcB, 32'd7);
    check("add_Operation", 32'(Operation), 32'h2);

    // EX/MEM forwarding and source priority on rs1 = x3.
    drive_id(1, 3, 0, 5, 32'd1, 0, 0, 0, 4'h2, 1, 0, 0);
    tick();
    set_fwd(1, 3, 32'hDEAD, 0, 0, 0);
    #1 check("fwd_exmem", SrcA, 32'hDEAD);
    set_fwd(1, 3, 32'h11, 1, 3, 32'h22);
    #1 check("fwd_both", SrcA, 32'h11);
    set_fwd(1, 0, 32'h11, 1, 3, 32'h22);
    #1 check("fwd_memwb", SrcA, 32'h22);
    set_fwd(1, 0, 32'h11, 1, 0, 32'h22);
    #1 check("fwd_x0", SrcA, 32'd1);
    set_fwd(0, 0, 0, 0, 0, 0);

    // Load-use on rs2 = x4: one stall cycle, a bubble, then the consumer enters.
    drive_id(1, 1, 0, 4, 0, 0, 0, 1, 4'h2, 1, 1, 0);
    tick();
    drive_id(1, 5, 4, 6, 32'h50, 32'h40, 0, 0, 4'h2, 1, 0, 0);
    #1 check("lu_stall", 32'(stall_o), 1);
    tick();
    #1 check("lu_bubble", 32'(ex_valid), 0);
    check("lu_stall_clear", 32'(stall_o), 0);
    tick();
    #1 check("lu_enter_valid", 32'(ex_valid), 1);
    check("lu_enter_rd", 32'(ex_rd), 6);
    set_fwd(0, 0, 0, 1, 4, 32'hABC);
    #1 check("lu_memwb_fwd", ex_store_data, 32'hABC);
    set_fwd(0, 0, 0, 0, 0, 0);

    // Flush coinciding with a load-use hazard.
    drive_id(1, 1, 0, 4, 0, 0, 0, 1, 4'h2, 1, 1, 0);
    tick();
    drive_id(1, 5, 4, 6, 0, 0, 0, 0, 4'h2, 1, 0, 0);
    flush = 1'b1;
    #1 check("flush_stall", 32'(stall_o), 0);
    tick();
    flush = 1'b0;
    #1 check("flush_bubble", 32'(ex_valid), 0);

    // Immediate operand with a forwarded store value.
    drive_id(1, 1, 9, 0, 0, 32'h3, 32'hFFFF_FFFC, 1, 4'h2, 0, 0, 1);
    tick();
    set_fwd(1, 9, 32'h9, 0, 0, 0);
    #1 check("imm_SrcB", SrcB, 32'hFFFF_FFFC);
    check("imm_store", ex_store_data, 32'h9);
    set_fwd(0, 0, 0, 0, 0, 0);

    // Reset asserted while a stall is being requested.
    drive_id(1, 1, 0, 4, 0, 0, 0, 1, 4'h2, 1, 1, 0);
    tick();
    drive_id(1, 4, 2, 6, 0, 0, 0, 0, 4'h2, 1, 0, 0);
    #1 check("rs_stall", 32'(stall_o), 1);
    #2 rst_n = 1'b0;
    m = bubble();
    #1 check("rs_stall_drop", 32'(stall_o), 0);
    check("rs_ex_valid", 32'(ex_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with a narrow register range to provoke hazards and hits.
    for (int i = 0; i < 400; i++) begin
      drive_id($urandom_range(0, 3) != 0,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom),
               1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
      flush = $urandom_range(0, 7) == 0;
      set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      tick();
    end
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
